// File: rtl/dcache_resp_merge.sv
// Reassembles two 256-bit bus beats per request-queue slot into one 512-bit line for the cache fill.
// Optional DCACHE_RESP_ERR_EN keeps per-slot error tracking; otherwise line_err is tied low.
module dcache_resp_merge #(
    parameter int unsigned NSLOT = 4,
    parameter int unsigned HALFW = 256,
    parameter int unsigned RNDXW = 6,
    localparam int unsigned SW = $clog2(NSLOT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_v,
    input  logic [SW-1:0]      alloc_slot,
    input  logic [RNDXW-1:0]   alloc_rndx,
    input  logic               resp_v,
    output logic               resp_rdy,
    input  logic [SW-1:0]      resp_slot,
    input  logic               resp_half,
    input  logic               resp_err,
    input  logic [HALFW-1:0]   resp_dat,
    output logic               line_v,
    input  logic               line_rdy,
    output logic [SW-1:0]      line_slot,
    output logic [RNDXW-1:0]   line_rndx,
    output logic [2*HALFW-1:0] line_dat,
    output logic               line_err,
    output logic [NSLOT-1:0]   slot_free,
    output logic               stray_o,
    output logic               dup_o
);

    typedef enum logic [1:0] {StIdle, StWait, StFull, StOut} slot_st_e;

    slot_st_e           st_q   [NSLOT];
    logic [1:0]         ld_q   [NSLOT];
    logic [RNDXW-1:0]   rndx_q [NSLOT];
    logic [2*HALFW-1:0] buf_q  [NSLOT];
    logic [SW-1:0]      rr_q;

    logic               line_v_q;
    logic [SW-1:0]      line_slot_q;
    logic [RNDXW-1:0]   line_rndx_q;
    logic [2*HALFW-1:0] line_dat_q;
    logic [NSLOT-1:0]   slot_free_q;
    logic               stray_q, dup_q;

    logic          accept, out_free, sel_v, alloc_ok;
    logic          beat, beat_wr, beat_dup, beat_stray;
    logic [SW-1:0] sel, idx;
    logic [1:0]    ld_nx;

    assign resp_rdy = !rst;

    always_comb begin
        accept   = line_v_q & line_rdy;
        out_free = !line_v_q | accept;
        sel_v    = 1'b0;
        sel      = rr_q;
        idx      = rr_q;
        // Round-robin search starting at the pointer; SW-bit add wraps since NSLOT is 2^SW.
        for (int unsigned k = 0; k < NSLOT; k++) begin
            idx = rr_q + SW'(k);
            if (!sel_v && st_q[idx] == StFull) begin
                sel_v = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        beat       = resp_v & resp_rdy;
        ld_nx      = ld_q[resp_slot] | (resp_half ? 2'b10 : 2'b01);
        beat_wr    = beat && st_q[resp_slot] == StWait && !ld_q[resp_slot][resp_half];
        beat_dup   = beat && st_q[resp_slot] != StIdle && ld_q[resp_slot][resp_half];
        beat_stray = beat && !beat_wr && !beat_dup;
        alloc_ok   = alloc_v && (st_q[alloc_slot] == StIdle ||
                                 (accept && line_slot_q == alloc_slot));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                st_q[i]   <= StIdle;
                ld_q[i]   <= '0;
                rndx_q[i] <= '0;
            end
            rr_q        <= '0;
            line_v_q    <= 1'b0;
            line_slot_q <= '0;
            line_rndx_q <= '0;
            line_dat_q  <= '0;
            slot_free_q <= '0;
            stray_q     <= 1'b0;
            dup_q       <= 1'b0;
        end else begin
            slot_free_q <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                if (accept && line_slot_q == SW'(i)) begin
                    st_q[i]        <= StIdle;
                    slot_free_q[i] <= 1'b1;
                end
                if (out_free && sel_v && sel == SW'(i)) begin
                    st_q[i] <= StOut;
                end
                if (beat_wr && resp_slot == SW'(i)) begin
                    ld_q[i] <= ld_nx;
                    if (ld_nx == 2'b11) begin
                        st_q[i] <= StFull;
                    end
                end
                // Last so that a same-cycle retire and re-allocate leaves the slot in WAIT.
                if (alloc_ok && alloc_slot == SW'(i)) begin
                    st_q[i]   <= StWait;
                    ld_q[i]   <= '0;
                    rndx_q[i] <= alloc_rndx;
                end
            end
            if (out_free) begin
                line_v_q <= sel_v;
                if (sel_v) begin
                    line_slot_q <= sel;
                    line_rndx_q <= rndx_q[sel];
                    line_dat_q  <= buf_q[sel];
                    rr_q        <= sel + SW'(1);
                end
            end
            stray_q <= stray_q | beat_stray;
            dup_q   <= dup_q | beat_dup;
        end
    end

    // Line data needs no reset: a slot only reaches FULL once both halves are written.
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            if (resp_half) begin
                buf_q[resp_slot][2*HALFW-1:HALFW] <= resp_dat;
            end else begin
                buf_q[resp_slot][HALFW-1:0] <= resp_dat;
            end
        end
    end

`ifdef DCACHE_RESP_ERR_EN
    logic [NSLOT-1:0] err_q;
    logic             line_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= '0;
            line_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                if (beat_wr && resp_slot == SW'(i)) begin
                    err_q[i] <= err_q[i] | resp_err;
                end
                if (alloc_ok && alloc_slot == SW'(i)) begin
                    err_q[i] <= 1'b0;
                end
            end
            if (out_free && sel_v) begin
                line_err_q <= err_q[sel];
            end
        end
    end

    assign line_err = line_err_q;
`else
    logic unused_resp_err;
    assign unused_resp_err = resp_err;
    assign line_err        = 1'b0;
`endif

    assign line_v    = line_v_q;
    assign line_slot = line_slot_q;
    assign line_rndx = line_rndx_q;
    assign line_dat  = line_dat_q;
    assign slot_free = slot_free_q;
    assign stray_o   = stray_q;
    assign dup_o     = dup_q;

endmodule

// File: tb/tb_dcache_resp_merge.sv
// Directed bench for dcache_resp_merge: fill order, backpressure, round-robin, flags, reset.
module tb_dcache_resp_merge;

    localparam int unsigned NSLOT = 4;
    localparam int unsigned HALFW = 256;
    localparam int unsigned RNDXW = 6;
    localparam int unsigned SW    = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               alloc_v;
    logic [SW-1:0]      alloc_slot;
    logic [RNDXW-1:0]   alloc_rndx;
    logic               resp_v;
    logic               resp_rdy;
    logic [SW-1:0]      resp_slot;
    logic               resp_half;
    logic               resp_err;
    logic [HALFW-1:0]   resp_dat;
    logic               line_v;
    logic               line_rdy;
    logic [SW-1:0]      line_slot;
    logic [RNDXW-1:0]   line_rndx;
    logic [2*HALFW-1:0] line_dat;
    logic               line_err;
    logic [NSLOT-1:0]   slot_free;
    logic               stray_o;
    logic               dup_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [HALFW-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f, pat_g;
    logic [HALFW-1:0] lo [NSLOT];
    logic [HALFW-1:0] hi [NSLOT];
    logic             exp_err;

    always #5 clk = ~clk;

    dcache_resp_merge #(
        .NSLOT(NSLOT),
        .HALFW(HALFW),
        .RNDXW(RNDXW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alloc_v   (alloc_v),
        .alloc_slot(alloc_slot),
        .alloc_rndx(alloc_rndx),
        .resp_v    (resp_v),
        .resp_rdy  (resp_rdy),
        .resp_slot (resp_slot),
        .resp_half (resp_half),
        .resp_err  (resp_err),
        .resp_dat  (resp_dat),
        .line_v    (line_v),
        .line_rdy  (line_rdy),
        .line_slot (line_slot),
        .line_rndx (line_rndx),
        .line_dat  (line_dat),
        .line_err  (line_err),
        .slot_free (slot_free),
        .stray_o   (stray_o),
        .dup_o     (dup_o)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [SW-1:0] s, input logic [RNDXW-1:0] r);
        alloc_v    = 1'b1;
        alloc_slot = s;
        alloc_rndx = r;
        tick();
        alloc_v    = 1'b0;
    endtask

    task automatic do_beat(input logic [SW-1:0] s, input logic h, input logic [HALFW-1:0] d,
                           input logic e);
        resp_v    = 1'b1;
        resp_slot = s;
        resp_half = h;
        resp_dat  = d;
        resp_err  = e;
        tick();
        resp_v    = 1'b0;
        resp_err  = 1'b0;
    endtask

    initial begin
        pat_a = {8{32'hAAAA_AAAA}};
        pat_b = {8{32'hBBBB_BBBB}};
        pat_c = {8{32'hCCCC_CCCC}};
        pat_d = {8{32'hDDDD_DDDD}};
        pat_e = {8{32'hEEEE_EEEE}};
        pat_f = {8{32'hFFFF_FFFF}};
        pat_g = {8{32'h1234_5678}};
        for (int s = 0; s < NSLOT; s++) begin
            lo[s] = {32{8'(8'h10 + s)}};
            hi[s] = {32{8'(8'h20 + s)}};
        end
`ifdef DCACHE_RESP_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        rst = 1'b1; alloc_v = 1'b0; alloc_slot = '0; alloc_rndx = '0;
        resp_v = 1'b0; resp_slot = '0; resp_half = 1'b0; resp_err = 1'b0; resp_dat = '0;
        line_rdy = 1'b0;
        tick();
        tick();
        chk("rst_resp_rdy", resp_rdy, 0);
        chk("rst_line_v", line_v, 0);
        chk("rst_line_dat", line_dat, 0);
        chk("rst_line_slot", line_slot, 0);
        chk("rst_slot_free", slot_free, 0);
        chk("rst_flags", {stray_o, dup_o, line_err}, 0);
        rst = 1'b0;
        #1;
        chk("resp_rdy_run", resp_rdy, 1);

        // Basic fill of slot 1.
        do_alloc(2'd1, 6'd5);
        do_beat(2'd1, 1'b0, pat_a, 1'b0);
        do_beat(2'd1, 1'b1, pat_b, 1'b0);
        chk("basic_lat_n1", line_v, 0);
        tick();
        chk("basic_line_v", line_v, 1);
        chk("basic_slot", line_slot, 1);
        chk("basic_rndx", line_rndx, 5);
        chk("basic_dat", line_dat, {pat_b, pat_a});
        chk("basic_err", line_err, 0);
        line_rdy = 1'b1;
        tick();
        line_rdy = 1'b0;
        chk("basic_free", slot_free, 4'b0010);
        chk("basic_v_after", line_v, 0);
        tick();
        chk("basic_free_pulse", slot_free, 4'b0000);

        // High-first on slot 2.
        do_alloc(2'd2, 6'd9);
        do_beat(2'd2, 1'b1, pat_c, 1'b0);
        do_beat(2'd2, 1'b0, pat_d, 1'b0);
        tick();
        chk("hf_line_v", line_v, 1);
        chk("hf_slot", line_slot, 2);
        chk("hf_rndx", line_rndx, 9);
        chk("hf_dat", line_dat, {pat_c, pat_d});
        chk("hf_dup", dup_o, 0);
        line_rdy = 1'b1;
        tick();
        line_rdy = 1'b0;
        chk("hf_free", slot_free, 4'b0100);

        // Stray beat to idle slot 3, then duplicate low beat and an erroring high beat.
        do_beat(2'd3, 1'b0, pat_e, 1'b0);
        chk("stray_set", stray_o, 1);
        tick();
        tick();
        chk("stray_no_line", line_v, 0);
        do_alloc(2'd3, 6'd7);
        do_beat(2'd3, 1'b0, pat_e, 1'b0);
        do_beat(2'd3, 1'b0, pat_f, 1'b0);
        chk("dup_set", dup_o, 1);
        do_beat(2'd3, 1'b1, pat_g, 1'b1);
        tick();
        chk("err_line_v", line_v, 1);
        chk("dup_kept_dat", line_dat, {pat_g, pat_e});
        chk("err_prop", line_err, exp_err);
        line_rdy = 1'b1;
        tick();
        line_rdy = 1'b0;
        chk("err_free", slot_free, 4'b1000);

        // All four slots full under backpressure, then drained in round-robin order.
        for (int s = 0; s < NSLOT; s++) do_alloc(2'(s), 6'(10 + s));
        for (int s = 0; s < NSLOT; s++) do_beat(2'(s), 1'b0, lo[s], 1'b0);
        for (int s = 0; s < NSLOT; s++) do_beat(2'(s), 1'b1, hi[s], 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold_v", line_v, 1);
            chk("bp_hold_slot", line_slot, 0);
            chk("bp_hold_dat", line_dat, {hi[0], lo[0]});
        end
        chk("bp_s0_err", line_err, 0);
        chk("bp_s0_rndx", line_rndx, 10);
        line_rdy = 1'b1;
        tick();
        chk("rr_s1", line_slot, 1);
        chk("rr_s1_rndx", line_rndx, 11);
        chk("rr_free0", slot_free, 4'b0001);
        tick();
        chk("rr_s2", line_slot, 2);
        chk("rr_s2_dat", line_dat, {hi[2], lo[2]});
        chk("rr_free1", slot_free, 4'b0010);
        tick();
        chk("rr_s3", line_slot, 3);
        chk("rr_s3_v", line_v, 1);
        chk("rr_free2", slot_free, 4'b0100);
        tick();
        chk("rr_drained", line_v, 0);
        chk("rr_free3", slot_free, 4'b1000);
        line_rdy = 1'b0;

        // Reset with slot 0 half-loaded and slot 1 presented.
        do_alloc(2'd0, 6'd1);
        do_alloc(2'd1, 6'd2);
        do_beat(2'd1, 1'b0, pat_a, 1'b0);
        do_beat(2'd1, 1'b1, pat_b, 1'b0);
        do_beat(2'd0, 1'b0, pat_c, 1'b0);
        chk("pre_rst_v", line_v, 1);
        chk("pre_rst_slot", line_slot, 1);
        rst = 1'b1;
        line_rdy = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_v", line_v, 0);
        chk("mid_rst_free", slot_free, 0);
        chk("mid_rst_flags", {stray_o, dup_o}, 0);
        tick();
        chk("mid_rst_free2", slot_free, 0);
        line_rdy = 1'b0;
        do_alloc(2'd0, 6'd3);
        do_beat(2'd0, 1'b0, pat_f, 1'b0);
        do_beat(2'd0, 1'b1, pat_d, 1'b0);
        tick();
        chk("post_rst_v", line_v, 1);
        chk("post_rst_slot", line_slot, 0);
        chk("post_rst_rndx", line_rndx, 3);
        chk("post_rst_dat", line_dat, {pat_d, pat_f});
        chk("post_rst_dup", dup_o, 0);
        line_rdy = 1'b1;
        tick();
        line_rdy = 1'b0;
        chk("post_rst_free", slot_free, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_resp_merge.md
# dcache_resp_merge

Collects the two 256-bit bus response beats returned for each data-cache request-queue slot and reassembles them into a single 512-bit line for the cache fill path. It sits between the bus response port and the data-cache line RAM. It is the receive-side counterpart of the request queue that splits each 512-bit CPU request into two 256-bit transactions. It tracks per-slot `loaded` halves, buffers partial lines, and presents completed lines to the cache under a valid/ready handshake.

## Interface
- `NSLOT`, 4: request-queue slots; power of two, 2..16.
- `HALFW`, 256: bus beat width; line width is 2*`HALFW`.
- `clk` in 1: clock.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `alloc_v` in 1: the queue allocates a slot for a load or fill.
- `alloc_slot` in $clog2(NSLOT): index of the allocated slot.
- `alloc_rndx` in $bits(cpu_types_pkg::rob_ndx_t): ROB index of the owning instruction.
- `resp_v` in 1: a bus response beat is valid.
- `resp_rdy` out 1: a beat is accepted; 0 while `rst`, otherwise 1.
- `resp_slot` in $clog2(NSLOT): slot tag carried by the response.
- `resp_half` in 1: 0 = low 256 bits, 1 = high 256 bits.
- `resp_err` in 1: bus error on this beat.
- `resp_dat` in HALFW: beat data.
- `line_v` out 1: a completed line is presented.
- `line_rdy` in 1: the cache accepts the line.
- `line_slot` out $clog2(NSLOT): slot of the presented line.
- `line_rndx` out rob_ndx_t: ROB index of the presented line.
- `line_dat` out 2*HALFW: assembled line, low half in bits [HALFW-1:0].
- `line_err` out 1: OR of `resp_err` over both beats.
- `slot_free` out NSLOT: one-cycle pulse per slot when it retires.
- `stray_o` out 1: sticky flag; set by a beat to an IDLE slot.
- `dup_o` out 1: sticky flag; set by a beat to an already-loaded half.

## Operation
- Per-slot state: IDLE, WAIT, FULL, OUT. Per-slot registers: `loaded[1:0]`, `err`, `rndx`, 512-bit buffer.
- **IDLE → WAIT:** on `alloc_v`. Clears `loaded`, clears `err`, and latches `rndx`.
  - Allocation is honoured if the slot is IDLE, or if it is retiring in the same cycle.
  - Any other allocation is ignored with no state change.
- **Beat acceptance:** on `resp_v` to a WAIT slot, write `resp_dat` into half `resp_half`, set `loaded[resp_half]`, and OR in `err`.
  - A beat to an IDLE, FULL or OUT slot is dropped and sets `stray_o`. Exception: FULL/OUT with the half already loaded sets `dup_o` instead.
  - A beat to a WAIT slot whose half is already loaded is dropped (data is not overwritten) and sets `dup_o`.
- **WAIT → FULL:** when `loaded` becomes 2'b11. This includes the case where the second beat arrives in the same cycle as the first would have completed it.
- **FULL → OUT:** a round-robin arbiter selects one FULL slot when the output register is empty or being accepted this cycle.
  - The round-robin pointer advances to selected+1.
  - The selected slot's data is copied into the output register.
- **OUT → IDLE:** on `line_v & line_rdy`. The slot's `slot_free` bit pulses on the following cycle.
- `line_*` stays stable while `line_v & !line_rdy`.
- Beats for different slots may interleave in any order; halves may arrive high-first.

## Timing
- **Reset:** all slots IDLE; `loaded`=0; round-robin pointer=0; `line_v`=0; `line_slot`, `line_rndx`, `line_dat` and `line_err` are 0; `slot_free`=0; `stray_o`=0; `dup_o`=0; `resp_rdy`=0. Reset mid-operation discards all partial and pending lines without pulsing `slot_free`.
- **Latency:** second beat accepted at edge n → slot FULL in cycle n+1 → `line_v`=1 in cycle n+2.
- **Back-to-back output:** with `line_rdy` held at 1, one line per cycle.
- **Free pulse:** accept at edge n → `slot_free` pulse in cycle n+1.
- **Same-cycle events:**
  - `alloc_v` and `resp_v` to the same IDLE slot in the same cycle: the allocation wins and the beat is stray.
  - Accept and re-allocate of the same slot in the same cycle: the slot ends in WAIT.

## Configuration
- `DCACHE_RESP_ERR_EN` defined: per-slot `err` register is present and `line_err` reports the OR of both beats' `resp_err`.
- `DCACHE_RESP_ERR_EN` undefined: `resp_err` is ignored, the `err` registers are removed, and `line_err` is tied to 0.

## Test plan
- **Basic fill:** alloc slot 1 (rndx=5); beats low=A…A, high=B…B at cycles 3 and 4 → `line_v` at cycle 6 with `line_slot`=1, `line_rndx`=5, `line_dat`={B,A}; accept → `slot_free`=4'b0010 next cycle.
- **High-first order:** slot 2 receives the high beat then the low beat → identical assembled line; `dup_o`=0.
- **Backpressure and round-robin:** slots 0..3 all FULL, `line_rdy`=0 for 5 cycles → output held stable on slot 0; then `line_rdy`=1 → slots 0, 1, 2, 3 on consecutive cycles.
- **Error flags:** a beat to IDLE slot 3 → `stray_o`=1 with no line produced. A repeat low beat to a WAIT slot → `dup_o`=1 and the original data is kept.
- **Error propagation:** `resp_err`=1 on the high beat only → `line_err`=1 with `DCACHE_RESP_ERR_EN` defined, 0 without.
- **Reset mid-operation:** `rst` asserted with slot 0 half-loaded and slot 1 presented → next cycle `line_v`=0, no `slot_free` pulse, and a fresh alloc/fill of slot 0 completes normally.
